// File: rtl/imem_loader_pkg.sv
// Shared types and frame constants for the instruction-memory boot loader.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        S_LEN0,
        S_LEN1,
        S_DATA,
        S_CSUM,
        S_DONE,
        S_ERR
    } state_t;

    localparam int LEN_BYTES      = 2;
    localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the boot loader.
interface imem_loader_if #(
    parameter int ADDR_W = 8
);
    logic              rx_valid;
    logic [7:0]        rx_data;
    logic              rx_ready;
    logic              im_we;
    logic [ADDR_W-1:0] im_addr;
    logic [31:0]       im_wdata;

    // The loader consumes the byte stream and drives the memory write port.
    modport master (
        input  rx_valid, rx_data,
        output rx_ready, im_we, im_addr, im_wdata
    );

    modport slave (
        output rx_valid, rx_data,
        input  rx_ready, im_we, im_addr, im_wdata
    );
endinterface

// File: rtl/imem_loader_byte_packer.sv
// Assembles pushed bytes into little-endian 32-bit words, flagging the 4th push.
module byte_packer
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_clear,
    input  logic        i_push,
    input  logic [7:0]  i_byte,
    output logic [31:0] o_word,
    output logic        o_word_ready
);

    logic [1:0]  r_lane;
    logic [23:0] r_shift;

    // The 4th byte bypasses the register, so the full word is ready on that push.
    assign o_word_ready = i_push && (r_lane == 2'(BYTES_PER_WORD - 1));
    assign o_word       = {i_byte, r_shift};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lane  <= 2'd0;
            r_shift <= 24'd0;
        end else if (i_clear) begin
            r_lane  <= 2'd0;
            r_shift <= 24'd0;
        end else if (i_push) begin
            r_lane  <= r_lane + 2'd1;
            r_shift <= {i_byte, r_shift[23:8]};
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: parses a length/words/checksum frame into instruction memory and
// holds the core in reset until a verified image has been written.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int IMEM_DEPTH = 256,
    parameter int ADDR_W     = $clog2(IMEM_DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    imem_loader_if.master bus,
    input  logic          restart,
    output logic          core_rst,
    output logic          done,
    output logic          error
);

    localparam logic [15:0] DEPTH_W = 16'(IMEM_DEPTH);

    state_t            r_state;
    state_t            w_nextState;
    logic [15:0]       r_len;
    logic [15:0]       r_wordCnt;
    logic [7:0]        r_xor;
    logic              r_imWe;
    logic [ADDR_W-1:0] r_imAddr;
    logic [31:0]       r_imWdata;

    logic              w_rxReady;
    logic              w_accept;
    logic              w_push;
    logic              w_clear;
    logic              w_lastWord;
    logic [15:0]       w_lenWord;
    logic [31:0]       w_word;
    logic              w_wordReady;

    assign w_rxReady  = (r_state == S_LEN0) || (r_state == S_LEN1) ||
                        (r_state == S_DATA) || (r_state == S_CSUM);
    assign w_accept   = bus.rx_valid && w_rxReady;
    assign w_push     = w_accept && (r_state == S_DATA);
    assign w_clear    = restart && ((r_state == S_DONE) || (r_state == S_ERR));
    assign w_lenWord  = {bus.rx_data, r_len[7:0]};
    // 16-bit compare so a full-depth image (N == IMEM_DEPTH) still terminates.
    assign w_lastWord = (r_wordCnt + 16'd1) == r_len;

    assign bus.rx_ready = w_rxReady;
    assign bus.im_we    = r_imWe;
    assign bus.im_addr  = r_imAddr;
    assign bus.im_wdata = r_imWdata;

    byte_packer u_packer (
        .clk          (clk),
        .rst          (rst),
        .i_clear      (w_clear),
        .i_push       (w_push),
        .i_byte       (bus.rx_data),
        .o_word       (w_word),
        .o_word_ready (w_wordReady)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_LEN0;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        core_rst    = 1'b1;
        done        = 1'b0;
        error       = 1'b0;
        case (r_state)
            S_LEN0: begin
                if (w_accept) w_nextState = S_LEN1;
            end
            S_LEN1: begin
                if (w_accept) begin
                    if (w_lenWord > DEPTH_W)      w_nextState = S_ERR;
                    else if (w_lenWord == 16'd0)  w_nextState = S_CSUM;
                    else                          w_nextState = S_DATA;
                end
            end
            S_DATA: begin
                if (w_wordReady && w_lastWord) w_nextState = S_CSUM;
            end
            S_CSUM: begin
                if (w_accept) w_nextState = (bus.rx_data == r_xor) ? S_DONE : S_ERR;
            end
            S_DONE: begin
                core_rst = 1'b0;
                done     = 1'b1;
                if (restart) w_nextState = S_LEN0;
            end
            S_ERR: begin
                error = 1'b1;
                if (restart) w_nextState = S_LEN0;
            end
            default: w_nextState = S_LEN0;
        endcase
    end

    // Length latch, checksum accumulation, word counting and registered write port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_len     <= 16'd0;
            r_wordCnt <= 16'd0;
            r_xor     <= 8'd0;
            r_imWe    <= 1'b0;
            r_imAddr  <= '0;
            r_imWdata <= 32'd0;
        end else begin
            r_imWe <= 1'b0;
            if (w_clear) begin
                r_len     <= 16'd0;
                r_wordCnt <= 16'd0;
                r_xor     <= 8'd0;
            end
            if (w_accept) begin
                case (r_state)
                    S_LEN0: begin
                        r_len[7:0] <= bus.rx_data;
                        r_xor      <= r_xor ^ bus.rx_data;
                    end
                    S_LEN1: begin
                        r_len[15:8] <= bus.rx_data;
                        r_xor       <= r_xor ^ bus.rx_data;
                    end
                    S_DATA: begin
                        r_xor <= r_xor ^ bus.rx_data;
                    end
                    default: ;
                endcase
            end
            if (w_wordReady) begin
                r_imWe    <= 1'b1;
                r_imAddr  <= r_wordCnt[ADDR_W-1:0];
                r_imWdata <= w_word;
                r_wordCnt <= r_wordCnt + 16'd1;
            end
        end
    end

endmodule
